// File: rtl/alu_flag_trap_if.sv
// rtl/alu_flag_trap_if.sv - operation stream and trap handshake between ALU, flag trap block and control unit
interface alu_flag_trap_if #(
    parameter int PC_WIDTH = 32
);
    logic                in_valid;
    logic                in_ready;
    logic [3:0]          aluop;
    logic                zero;
    logic                of;
    logic                uof;
    logic [PC_WIDTH-1:0] pc;
    logic                trap_req;
    logic [1:0]          trap_cause;
    logic [PC_WIDTH-1:0] trap_pc;
    logic                trap_ack;

    modport master (
        output in_valid, aluop, zero, of, uof, pc, trap_ack,
        input  in_ready, trap_req, trap_cause, trap_pc
    );

    modport slave (
        input  in_valid, aluop, zero, of, uof, pc, trap_ack,
        output in_ready, trap_req, trap_cause, trap_pc
    );
endinterface

// File: rtl/alu_flag_trap.sv
// rtl/alu_flag_trap.sv - architectural flag register, sticky overflow tracking and overflow trap handshake
module alu_flag_trap #(
    parameter int PC_WIDTH  = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_flag_trap_if.slave       bus,
    input  logic                 trap_en_of,
    input  logic                 trap_en_uof,
    input  logic                 sticky_clr,
    output logic                 flag_zero,
    output logic                 flag_of,
    output logic                 flag_uof,
    output logic                 sticky_of,
    output logic                 sticky_uof,
    output logic [CNT_WIDTH-1:0] ovf_count
);
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        TRAP  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    state_t              state;
    state_t              state_nxt;
    logic                accept;
    logic                ov_ok;
    logic                g_of;
    logic                g_uof;
    logic                t_of;
    logic                t_uof;
    logic                take_trap;
    logic [1:0]          cause_q;
    logic [PC_WIDTH-1:0] pc_q;

    // Overflow flags only mean something for add/sub; other ops report zero only.
    assign ov_ok     = (bus.aluop == 4'd5) || (bus.aluop == 4'd6);
    assign g_of      = bus.of  & ov_ok;
    assign g_uof     = bus.uof & ov_ok;
    assign t_of      = g_of  & trap_en_of;
    assign t_uof     = g_uof & trap_en_uof;

    assign bus.in_ready   = (state == RUN);
    assign bus.trap_req   = (state == TRAP);
    assign bus.trap_cause = cause_q;
    assign bus.trap_pc    = pc_q;

    assign accept    = bus.in_valid & bus.in_ready;
    assign take_trap = accept & (t_of | t_uof);

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (take_trap)    state_nxt = TRAP;
            TRAP:    if (bus.trap_ack) state_nxt = DRAIN;
            DRAIN:   state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_zero  <= 1'b0;
            flag_of    <= 1'b0;
            flag_uof   <= 1'b0;
            sticky_of  <= 1'b0;
            sticky_uof <= 1'b0;
            ovf_count  <= '0;
            cause_q    <= 2'b00;
            pc_q       <= '0;
        end else begin
            if (accept) begin
                flag_zero <= bus.zero;
                flag_of   <= g_of;
                flag_uof  <= g_uof;
            end

            // A clear on the same edge as an overflowing accept discards that overflow.
            if (sticky_clr) begin
                sticky_of  <= 1'b0;
                sticky_uof <= 1'b0;
                ovf_count  <= '0;
            end else if (accept) begin
                sticky_of  <= sticky_of  | g_of;
                sticky_uof <= sticky_uof | g_uof;
                if ((g_of | g_uof) && (ovf_count != CNT_MAX)) begin
                    ovf_count <= ovf_count + CNT_WIDTH'(1);
                end
            end

            if (take_trap) begin
                cause_q <= {t_uof, t_of};
                pc_q    <= bus.pc;
            end else if ((state == TRAP) && bus.trap_ack) begin
                cause_q <= 2'b00;
            end
        end
    end
endmodule

// File: tb/tb_alu_flag_trap.sv
// tb/tb_alu_flag_trap.sv - randomized and directed self-checking bench for alu_flag_trap
module tb_alu_flag_trap;
    localparam int PCW  = 32;
    localparam int CW   = 8;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          trap_en_of;
    logic          trap_en_uof;
    logic          sticky_clr;
    logic          flag_zero;
    logic          flag_of;
    logic          flag_uof;
    logic          sticky_of;
    logic          sticky_uof;
    logic [CW-1:0] ovf_count;

    always #5 clk = ~clk;

    alu_flag_trap_if #(.PC_WIDTH(PCW)) bus ();

    alu_flag_trap #(.PC_WIDTH(PCW), .CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .trap_en_of (trap_en_of),
        .trap_en_uof(trap_en_uof),
        .sticky_clr (sticky_clr),
        .flag_zero  (flag_zero),
        .flag_of    (flag_of),
        .flag_uof   (flag_uof),
        .sticky_of  (sticky_of),
        .sticky_uof (sticky_uof),
        .ovf_count  (ovf_count)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // reference state: pending trap, one-cycle drain window, architectural flags and stats
    bit        m_trap, m_drain;
    bit        m_fz, m_fo, m_fu, m_so, m_su;
    int        m_cnt;
    bit [1:0]  m_cause;
    bit [31:0] m_pc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_trap = 0; m_drain = 0;
        m_fz = 0; m_fo = 0; m_fu = 0; m_so = 0; m_su = 0;
        m_cnt = 0; m_cause = 0; m_pc = 0;
    endfunction

    function automatic void model_edge();
        bit rdy = !(m_trap || m_drain);
        bit acc = bus.in_valid && rdy;
        bit ok  = (bus.aluop == 4'd5) || (bus.aluop == 4'd6);
        bit go  = bus.of  && ok;
        bit gu  = bus.uof && ok;
        bit to  = go && trap_en_of;
        bit tu  = gu && trap_en_uof;
        if (acc) begin
            m_fz = bus.zero; m_fo = go; m_fu = gu;
        end
        if (sticky_clr) begin
            m_so = 0; m_su = 0; m_cnt = 0;
        end else if (acc) begin
            m_so = m_so || go;
            m_su = m_su || gu;
            if (go || gu) m_cnt = (m_cnt >= MAXC) ? MAXC : m_cnt + 1;
        end
        if (m_drain) begin
            m_drain = 0;
        end else if (m_trap) begin
            if (bus.trap_ack) begin
                m_trap = 0; m_drain = 1; m_cause = 0;
            end
        end else if (acc && (to || tu)) begin
            m_trap = 1; m_cause = {tu, to}; m_pc = bus.pc;
        end
    endfunction

    task automatic compare_all();
        check("in_ready",   bus.in_ready,   !(m_trap || m_drain));
        check("trap_req",   bus.trap_req,   m_trap);
        check("trap_cause", bus.trap_cause, m_cause);
        check("trap_pc",    bus.trap_pc,    m_pc);
        check("flag_zero",  flag_zero,      m_fz);
        check("flag_of",    flag_of,        m_fo);
        check("flag_uof",   flag_uof,       m_fu);
        check("sticky_of",  sticky_of,      m_so);
        check("sticky_uof", sticky_uof,     m_su);
        check("ovf_count",  ovf_count,      m_cnt);
    endtask

    task automatic drive(input bit v, input int op, input bit z, input bit o, input bit u,
                         input logic [31:0] p, input bit eo, input bit eu, input bit clr, input bit ack);
        bus.in_valid = v;  bus.aluop = op[3:0]; bus.zero = z; bus.of = o; bus.uof = u;
        bus.pc = p; trap_en_of = eo; trap_en_uof = eu; sticky_clr = clr; bus.trap_ack = ack;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    logic [CW-1:0] saved_cnt;

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0);
        #3;
        model_reset();
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // add with signed overflow, trap enabled
        drive(1, 5, 0, 1, 0, 32'h0040_0010, 1, 0, 0, 0);
        tick();
        check("t1_trap_req",  bus.trap_req,   1'b1);
        check("t1_cause",     bus.trap_cause, 2'b01);
        check("t1_pc",        bus.trap_pc,    32'h0040_0010);
        check("t1_flag_of",   flag_of,        1'b1);
        check("t1_sticky_of", sticky_of,      1'b1);
        check("t1_count",     ovf_count,      1);
        check("t1_in_ready",  bus.in_ready,   1'b0);

        // hold without ack, then ack
        drive(0, 5, 0, 0, 0, 32'h0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t2_hold_req", bus.trap_req, 1'b1);
            check("t2_hold_pc",  bus.trap_pc,  32'h0040_0010);
        end
        bus.trap_ack = 1'b1;
        tick();
        check("t2_drain_req",   bus.trap_req,   1'b0);
        check("t2_drain_rdy",   bus.in_ready,   1'b0);
        check("t2_drain_cause", bus.trap_cause, 2'b00);
        bus.trap_ack = 1'b0;
        tick();
        check("t2_run_rdy", bus.in_ready, 1'b1);

        // sub with both overflows
        drive(1, 6, 0, 1, 1, 32'h0040_0020, 1, 1, 0, 0);
        tick();
        check("t3_cause", bus.trap_cause, 2'b11);
        drive(0, 6, 0, 0, 0, 32'h0, 0, 0, 0, 1);
        tick();
        bus.trap_ack = 1'b0;
        tick();
        drive(1, 6, 0, 1, 1, 32'h0040_0030, 0, 0, 0, 0);
        tick();
        check("t3_no_trap", bus.trap_req, 1'b0);
        check("t3_sticky",  {sticky_uof, sticky_of}, 2'b11);
        check("t3_count",   ovf_count, 3);

        // non add/sub op: overflow ignored, zero kept
        drive(1, 2, 1, 1, 1, 32'h0040_0040, 1, 1, 0, 0);
        tick();
        check("t4_no_trap", bus.trap_req, 1'b0);
        check("t4_fz",      flag_zero,    1'b1);
        check("t4_fof",     {flag_uof, flag_of}, 2'b00);
        check("t4_count",   ovf_count,    3);

        // counter saturation
        drive(0, 5, 0, 0, 0, 32'h0, 0, 0, 1, 0);
        tick();
        drive(1, 5, 0, 1, 0, 32'h0, 0, 0, 0, 0);
        for (int i = 0; i < MAXC - 1; i++) tick();
        check("t5_preload", ovf_count, MAXC - 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5_sat", ovf_count, MAXC);
        end
        sticky_clr = 1'b1;
        tick();
        check("t5_clr_sticky", {sticky_uof, sticky_of}, 2'b00);
        check("t5_clr_count",  ovf_count, 0);
        check("t5_clr_flag",   flag_of,   1'b1);

        // held in_valid during trap, then async reset mid-trap
        drive(1, 5, 0, 1, 0, 32'h0040_0050, 1, 0, 0, 0);
        tick();
        saved_cnt = ovf_count;
        drive(1, 5, 0, 1, 1, 32'h0040_0060, 1, 1, 0, 0);
        tick();
        tick();
        check("t6_held_count", ovf_count, saved_cnt);
        check("t6_held_pc",    bus.trap_pc, 32'h0040_0050);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("t6_rst_req",   bus.trap_req, 1'b0);
        check("t6_rst_rdy",   bus.in_ready, 1'b1);
        check("t6_rst_flags", {flag_zero, flag_of, flag_uof, sticky_of, sticky_uof}, 5'b0);
        compare_all();
        drive(0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // randomized traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            int sel = $urandom_range(0, 3);
            int op  = (sel == 0) ? 5 : (sel == 1) ? 6 : $urandom_range(0, 15);
            drive($urandom_range(0, 9) < 7, op, $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 1), $urandom, $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 15) == 0, $urandom_range(0, 2) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_flag_trap.md
Name: alu_flag_trap

Overview:
- Sits directly downstream of the ALU flag generator and consumes its zero / signed-overflow / unsigned-overflow outputs once per accepted ALU operation.
- Registers the architectural flags and keeps sticky overflow bits plus a saturating overflow event counter.
- Raises a trap request, with cause and faulting PC, to the control unit when an enabled overflow occurs.
- Holds the trap and stalls the execute stage through a valid/ready handshake until the trap is acknowledged.

Parameters:
- PC_WIDTH, 32, width of the program-counter value captured with each operation.
- CNT_WIDTH, 16, width of the saturating overflow event counter.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  ALU result and flags valid this cycle.
- in_ready  output  1  block can accept an operation this cycle.
- aluop  input  4  operation code of the flagged operation (5 = add, 6 = sub).
- zero  input  1  equal flag from the ALU flag stage.
- of  input  1  signed overflow flag.
- uof  input  1  unsigned overflow flag.
- pc  input  PC_WIDTH  PC of the operation.
- trap_en_of  input  1  signed-overflow trap enable.
- trap_en_uof  input  1  unsigned-overflow trap enable.
- sticky_clr  input  1  synchronous clear of the sticky bits and the counter.
- trap_ack  input  1  control unit has taken the trap.
- flag_zero  output  1  registered zero flag of the last accepted operation.
- flag_of  output  1  registered signed-overflow flag of the last accepted operation.
- flag_uof  output  1  registered unsigned-overflow flag of the last accepted operation.
- sticky_of  output  1  set by any accepted of=1; cleared only by sticky_clr or reset.
- sticky_uof  output  1  set by any accepted uof=1; cleared only by sticky_clr or reset.
- ovf_count  output  CNT_WIDTH  count of accepted operations with of|uof; saturates.
- trap_req  output  1  trap pending.
- trap_cause  output  2  01 = signed, 10 = unsigned, 11 = both; 00 when no trap.
- trap_pc  output  PC_WIDTH  PC of the trapping operation.

Behaviour:
- Reset (rst_n low, asynchronous): all outputs go to 0 except in_ready = 1; FSM enters RUN.
- Accept condition: accept = in_valid & in_ready.
- On accept:
  - flag_* <= zero / of / uof; visible the cycle after accept.
  - sticky_* <= sticky_* | input flag.
  - ovf_count increments by 1 if (of|uof), stopping at all-ones.
- Overflow gating: of/uof are honoured only for aluop 5 or 6. For any other aluop, the accepted flags are forced to 0 for the flag, sticky, counter and trap logic; zero is always honoured.
- Trap condition on accept: t_of = of & trap_en_of; t_uof = uof & trap_en_uof.
- FSM states:
  - RUN: in_ready = 1. An accept with t_of|t_uof moves to TRAP next cycle, loading trap_pc <= pc and trap_cause <= {t_uof, t_of}. The flags, sticky bits and counter for that operation are still updated.
  - TRAP: trap_req = 1, in_ready = 0; trap_cause and trap_pc held stable. trap_ack moves to DRAIN next cycle; while trap_ack is low the state is held indefinitely.
  - DRAIN: one cycle; trap_req = 0, in_ready = 0; trap_cause cleared to 00; trap_pc holds its value. Unconditionally returns to RUN.
- Latency: accept to trap_req high is 1 cycle. trap_ack to in_ready high is 2 cycles.
- trap_ack outside TRAP is ignored.
- sticky_clr:
  - Clears the sticky bits and the counter in the same edge it is sampled.
  - If an accept occurs in the same cycle, the clear wins over set/increment for that edge (the accepted op's overflow is lost from the sticky state; flag_* still updates).
  - Has no effect on the FSM or the trap outputs.
- Enable changes during TRAP have no effect on the pending trap.
- An in_valid asserted while in_ready = 0 is not consumed; upstream holds it.
- Reset mid-TRAP drops trap_req immediately (asynchronously) and returns the FSM to RUN.
- Counter width rule: ovf_count compares against {CNT_WIDTH{1'b1}} before incrementing; no wrap-around.

Test Plan:
1. Reset then add (aluop = 5) with of=1, uof=0, trap_en_of=1, pc=0x00400010.
   -> next cycle: trap_req=1, trap_cause=01, trap_pc=0x00400010, flag_of=1, sticky_of=1, ovf_count=1, in_ready=0.
2. Hold trap_ack=0 for 5 cycles, then pulse trap_ack=1.
   -> trap_req stays 1 with stable outputs for all 5 cycles; 1 cycle after the ack edge trap_req=0 (DRAIN); 2 cycles after, in_ready=1.
3. Sub (aluop = 6) with of=1, uof=1, both enables=1.
   -> trap_cause=11. Same op with both enables=0 -> no trap; sticky_of=sticky_uof=1; ovf_count incremented.
4. aluop=2 with of=1, uof=1, zero=1, enables=1.
   -> no trap; flag_zero=1, flag_of=0, flag_uof=0; sticky bits and counter unchanged.
5. Preload ovf_count to 0xFFFE (CNT_WIDTH=16), then 3 overflowing accepts.
   -> counts 0xFFFF, 0xFFFF, 0xFFFF.
   sticky_clr asserted with a simultaneous overflowing accept -> sticky_*=0, ovf_count=0.
6. Assert rst_n=0 mid-TRAP between clock edges.
   -> trap_req=0, in_ready=1 and all flags 0 immediately, without waiting for a clock edge.
   in_valid held high while in_ready=0 -> no sticky or counter change until re-accepted.
